// File: rtl/moore_cmd_gen.sv
// Command front-end for the toggle Moore FSM: debounces the arm/toggle buttons
// and emits one-cycle 2-bit command pulses separated by an enforced idle gap.

module moore_cmd_gen_db #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2, deb, deb_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_q <= deb;
            if (s2 != deb) begin
                if (cnt == LAST) begin
                    deb <= s2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Only the rising debounced edge is a press; releases are ignored.
    assign press = deb & ~deb_q;
endmodule

module moore_cmd_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GAP_CYCLES      = 2,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_arm,
    input  logic       btn_tgl,
    output logic [1:0] cmd,
    output logic       armed,
    output logic [7:0] drop_cnt
);
    // Low two state bits are the command itself, so cmd comes straight off flops.
    localparam logic [2:0] IDLE  = 3'b000;
    localparam logic [2:0] TGL_P = 3'b001;
    localparam logic [2:0] ARM_P = 3'b010;
    localparam logic [2:0] GAP   = 3'b100;

    localparam logic [CNT_W-1:0] GLAST = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]       btn, press;
    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] gcnt;
    logic             pend_arm, pend_tgl;
    logic             clr_arm, clr_tgl, drop_a, drop_t;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_nxt;

    assign btn = {btn_tgl, btn_arm};

    for (genvar i = 0; i < 2; i++) begin : g_db
        moore_cmd_gen_db #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk  (clk),
            .reset(reset),
            .btn  (btn[i]),
            .press(press[i])
        );
    end

    // A flag being consumed this cycle frees its slot for a new event.
    always_comb begin
        clr_arm  = (state == IDLE) && pend_arm;
        clr_tgl  = (state == IDLE) && (pend_arm || (pend_tgl && armed));
        drop_a   = press[0] && pend_arm && !clr_arm;
        drop_t   = press[1] && ((pend_tgl && !clr_tgl) || (!armed && !pend_arm));
        drop_sum = {1'b0, drop_cnt} + {8'b0, drop_a} + {8'b0, drop_t};
        drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pend_arm)                state_nxt = ARM_P;
                else if (pend_tgl && armed)  state_nxt = TGL_P;
            end
            ARM_P, TGL_P:                    state_nxt = GAP;
            GAP:   if (gcnt == GLAST)        state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            gcnt     <= '0;
            pend_arm <= 1'b0;
            pend_tgl <= 1'b0;
            armed    <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gcnt     <= (state == GAP) ? gcnt + 1'b1 : '0;
            drop_cnt <= drop_nxt;
            if (press[0] && !drop_a) pend_arm <= 1'b1;
            else if (clr_arm)        pend_arm <= 1'b0;
            if (press[1] && !drop_t) pend_tgl <= 1'b1;
            else if (clr_tgl)        pend_tgl <= 1'b0;
            if (state_nxt == ARM_P)  armed <= 1'b1;
        end
    end

    assign cmd = state[1:0];
endmodule
